// File: rtl/viterbi_tb_ctrl.sv
// Traceback controller for an 8-state (K=4) Viterbi decoder.
// Collects one ACS decision column per trellis step and traces back from the
// supplied best state. The decoded frame is then streamed in forward time order.
module viterbi_tb_ctrl #(
    parameter int FRAME_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dec_valid,
    input  logic [7:0] dec_vec,
    output logic       dec_ready,
    input  logic [2:0] best_state,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] ZERO = PW'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TRACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   tb_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [2:0]      cur_state;

    // Decision columns and traced bits are storage only; reset does not clear them.
    logic [7:0]      mem    [FRAME_LEN];
    logic            bitbuf [FRAME_LEN];

    // Next-state logic for the fill / trace / emit sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                end else begin
                    state_next = IDLE;
                end
            end
            FILL: begin
                if (dec_valid && (wr_ptr == LAST)) begin
                    state_next = TRACE;
                end else begin
                    state_next = FILL;
                end
            end
            TRACE: begin
                if (tb_ptr == ZERO) begin
                    state_next = EMIT;
                end else begin
                    state_next = TRACE;
                end
            end
            EMIT: begin
                // start on the final handshake is not looked at: we go to IDLE only.
                if (out_ready && (rd_ptr == LAST)) begin
                    state_next = IDLE;
                end else begin
                    state_next = EMIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and data outputs decoded from the registered state and read pointer.
    always_comb begin
        dec_ready = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            FILL: begin
                dec_ready = 1'b1;
                busy      = 1'b1;
            end
            TRACE: begin
                busy = 1'b1;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = bitbuf[rd_ptr];
                out_last  = (rd_ptr == LAST);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // State register and pointers; every pointer is reloaded on entry to its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= ZERO;
            tb_ptr    <= ZERO;
            rd_ptr    <= ZERO;
            cur_state <= 3'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_ptr <= ZERO;
                    end
                end
                FILL: begin
                    if (dec_valid) begin
                        wr_ptr <= wr_ptr + ONE;
                        if (wr_ptr == LAST) begin
                            cur_state <= best_state;
                            tb_ptr    <= LAST;
                        end
                    end
                end
                TRACE: begin
                    // Predecessor = {decision bit of current state, current state[2:1]}.
                    cur_state <= {mem[tb_ptr][cur_state], cur_state[2:1]};
                    tb_ptr    <= tb_ptr - ONE;
                    if (tb_ptr == ZERO) begin
                        rd_ptr <= ZERO;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        rd_ptr <= rd_ptr + ONE;
                    end
                end
                default: begin
                    rd_ptr <= ZERO;
                end
            endcase
        end
    end

    // Decision column capture during FILL and traced-bit capture during TRACE.
    always_ff @(posedge clk) begin
        if (!rst && (state == FILL) && dec_valid) begin
            mem[wr_ptr] <= dec_vec;
        end
        if (!rst && (state == TRACE)) begin
            bitbuf[tb_ptr] <= cur_state[0];
        end
    end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Self-checking bench for viterbi_tb_ctrl: a 4-step instance for the directed
// scenarios and a 32-step instance fed from a random convolutional-encoder path.
module tb_viterbi_tb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic       a_start = 1'b0, a_dec_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_dec_vec = 8'h00;
    logic [2:0] a_best = 3'd0;
    logic       a_dec_ready, a_out_valid, a_out_bit, a_out_last, a_busy;

    logic       b_start = 1'b0, b_dec_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_dec_vec = 8'h00;
    logic [2:0] b_best = 3'd0;
    logic       b_dec_ready, b_out_valid, b_out_bit, b_out_last, b_busy;

    always #5 clk = ~clk;

    viterbi_tb_ctrl #(.FRAME_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .start(a_start), .dec_valid(a_dec_valid),
        .dec_vec(a_dec_vec), .dec_ready(a_dec_ready), .best_state(a_best),
        .out_valid(a_out_valid), .out_bit(a_out_bit), .out_last(a_out_last),
        .out_ready(a_out_ready), .busy(a_busy)
    );

    viterbi_tb_ctrl #(.FRAME_LEN(32)) dut32 (
        .clk(clk), .rst(rst), .start(b_start), .dec_valid(b_dec_valid),
        .dec_vec(b_dec_vec), .dec_ready(b_dec_ready), .best_state(b_best),
        .out_valid(b_out_valid), .out_bit(b_out_bit), .out_last(b_out_last),
        .out_ready(b_out_ready), .busy(b_busy)
    );

    // Reference traceback: walk predecessors from best state, collecting u = state mod 2.
    function automatic logic [31:0] ref_decode(input logic [7:0] cols [32], input int n, input int best);
        int s = best;
        int d;
        logic [31:0] r = 32'h0;
        for (int t = n - 1; t >= 0; t--) begin
            r[t] = ((s % 2) != 0);
            d = int'((cols[t] >> s) & 8'd1);
            s = d * 4 + s / 2;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame on the 4-step instance and feed its four columns.
    task automatic a_fill(input logic [7:0] cols [32], input logic [2:0] bs, input bit rand_valid,
                          input bit pulse_start, input bit wait_emit, output int ready_bad, output int lat);
        int i = 0;
        int guard = 0;
        ready_bad = 0;
        lat = 0;
        a_dec_valid = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = pulse_start;
        while (i < 4 && guard < 100) begin
            a_dec_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            a_dec_vec   = a_dec_valid ? cols[i] : 8'($urandom);
            a_best      = (a_dec_valid && i == 3) ? bs : 3'($urandom);
            if (a_dec_ready !== 1'b1) ready_bad++;
            tick();
            if (a_dec_valid) i++;
            guard++;
        end
        a_dec_valid = 1'b0;
        a_start = 1'b0;
        if (wait_emit) begin
            while (a_out_valid !== 1'b1 && lat < 50) begin
                tick();
                lat++;
            end
        end
    endtask

    // Drain four bits; mode 0 = always ready, 1 = pattern 1,0,0,1, 2 = random ready.
    task automatic a_collect(input int mode, input bit pulse_start, output logic [3:0] bits,
                             output logic [3:0] lasts, output int unstable, output int invalid);
        int i = 0;
        int cyc = 0;
        bit held = 0;
        logic hb, hl;
        logic r;
        bits = 4'h0;
        lasts = 4'h0;
        unstable = 0;
        invalid = 0;
        while (i < 4 && cyc < 200) begin
            case (mode)
                0: r = 1'b1;
                1: r = ((cyc % 4) == 0 || (cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            a_out_ready = r;
            a_start = pulse_start;
            if (a_out_valid !== 1'b1) invalid++;
            if (held && (a_out_bit !== hb || a_out_last !== hl)) unstable++;
            if (r) begin
                bits[i] = a_out_bit;
                lasts[i] = a_out_last;
                i++;
                held = 0;
            end else begin
                held = 1;
                hb = a_out_bit;
                hl = a_out_last;
            end
            tick();
            cyc++;
        end
        a_out_ready = 1'b0;
        a_start = 1'b0;
        if (i < 4) invalid += 100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (a_dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %b want 0", a_dec_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit: got %b want 0", a_out_bit); end
        checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", a_out_last); end
        checks++; if ({a_busy, b_busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {a_busy, b_busy}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_frame();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts;
        int bad, lat, unst, inv;
        foreach (cols[k]) cols[k] = 8'h00;
        a_fill(cols, 3'd0, 1'b0, 1'b0, 1'b1, bad, lat);
        checks++; if (bad !== 0) begin errors++; $display("FAIL t1_dec_ready: got %0d drops want 0", bad); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency: got %0d edges want 4", lat); end
        a_collect(0, 1'b0, bits, lasts, unst, inv);
        checks++; if (bits !== 4'b0000) begin errors++; $display("FAIL t1_bits: got %b want 0000", bits); end
        checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL t1_last: got %b want 1000", lasts); end
        checks++; if (inv !== 0) begin errors++; $display("FAIL t1_valid: got %0d gaps want 0", inv); end
    endtask

    task automatic test_known_frame();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts;
        int bad, lat, unst, inv;
        foreach (cols[k]) cols[k] = 8'h00;
        cols[3] = 8'h20;
        a_fill(cols, 3'd5, 1'b1, 1'b0, 1'b1, bad, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t2_latency: got %0d want 4", lat); end
        a_collect(0, 1'b0, bits, lasts, unst, inv);
        // bit order [3:0] = bits 3..0 of stream 1,1,0,1
        checks++; if (bits !== 4'b1011) begin errors++; $display("FAIL t2_bits: got %b want 1011", bits); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t2_busy_drop: got %b want 0", a_busy); end
    endtask

    task automatic test_stall();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts, exp;
        logic [2:0] bs;
        int bad, lat, unst, inv;
        for (int f = 0; f < 3; f++) begin
            foreach (cols[k]) cols[k] = 8'h00;
            cols[3] = 8'h20;
            bs = 3'd5;
            if (f > 0) begin
                foreach (cols[k]) cols[k] = 8'($urandom);
                bs = 3'($urandom);
            end
            exp = ref_decode(cols, 4, int'(bs)) & 32'hF;
            a_fill(cols, bs, 1'b1, 1'b0, 1'b1, bad, lat);
            a_collect(1, 1'b0, bits, lasts, unst, inv);
            checks++; if (bits !== exp) begin errors++; $display("FAIL t3_bits[%0d]: got %b want %b", f, bits, exp); end
            checks++; if (unst !== 0 || inv !== 0) begin errors++; $display("FAIL t3_stable[%0d]: got %0d/%0d want 0/0", f, unst, inv); end
            checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL t3_last[%0d]: got %b want 1000", f, lasts); end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts, exp;
        logic [2:0] bs;
        int bad, lat, unst, inv;
        a_dec_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_dec_vec = 8'($urandom);
            tick();
            checks++; if ({a_dec_ready, a_busy} !== 2'b00) begin errors++; $display("FAIL t4_idle[%0d]: got %b want 00", k, {a_dec_ready, a_busy}); end
        end
        a_dec_valid = 1'b0;
        foreach (cols[k]) cols[k] = 8'($urandom);
        bs = 3'($urandom);
        exp = ref_decode(cols, 4, int'(bs)) & 32'hF;
        a_fill(cols, bs, 1'b1, 1'b1, 1'b1, bad, lat);
        checks++; if (lat !== 4 || bad !== 0) begin errors++; $display("FAIL t4_fill: got lat=%0d drops=%0d want 4/0", lat, bad); end
        a_collect(2, 1'b1, bits, lasts, unst, inv);
        checks++; if (bits !== exp) begin errors++; $display("FAIL t4_bits: got %b want %b", bits, exp); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t4_final_start: got busy=%b want 0", a_busy); end
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL t4_no_queue: got busy=%b want 0", a_busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts;
        int bad, lat, unst, inv;
        foreach (cols[k]) cols[k] = 8'h00;
        cols[3] = 8'h20;
        a_fill(cols, 3'd5, 1'b0, 1'b0, 1'b0, bad, lat);
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({a_dec_ready, a_out_valid, a_out_bit, a_out_last, a_busy} !== 5'b00000) begin
            errors++; $display("FAIL t5_reset_outputs: got %b want 00000", {a_dec_ready, a_out_valid, a_out_bit, a_out_last, a_busy});
        end
        rst = 1'b0;
        tick();
        a_fill(cols, 3'd5, 1'b0, 1'b0, 1'b1, bad, lat);
        a_collect(0, 1'b0, bits, lasts, unst, inv);
        checks++; if (bits !== 4'b1011) begin errors++; $display("FAIL t5_bits: got %b want 1011", bits); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cols [32];
        logic [3:0] bits, lasts, exp;
        logic [2:0] bs;
        int bad, lat, unst, inv;
        for (int f = 0; f < 4; f++) begin
            foreach (cols[k]) cols[k] = 8'($urandom);
            bs = 3'($urandom);
            exp = ref_decode(cols, 4, int'(bs)) & 32'hF;
            a_fill(cols, bs, 1'b0, 1'b0, 1'b1, bad, lat);
            a_collect(2, 1'b0, bits, lasts, unst, inv);
            checks++; if (bits !== exp || inv !== 0) begin errors++; $display("FAIL b2b_bits[%0d]: got %b want %b", f, bits, exp); end
        end
    endtask

    // Noiseless decoder model: decisions on the true path point at the real predecessor.
    task automatic test_random_frame();
        logic [7:0] cols [32];
        logic [31:0] u, bits, lasts;
        int s, ns, i, g, lat;
        for (int f = 0; f < 3; f++) begin
            u = $urandom;
            s = 0;
            for (int t = 0; t < 32; t++) begin
                ns = (s * 2 + int'(u[t])) % 8;
                cols[t] = 8'($urandom);
                cols[t][ns] = (s >= 4);
                s = ns;
            end
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            i = 0;
            g = 0;
            while (i < 32 && g < 500) begin
                b_dec_valid = 1'($urandom_range(0, 1));
                b_dec_vec = b_dec_valid ? cols[i] : 8'($urandom);
                b_best = (i == 31) ? 3'(s) : 3'($urandom);
                tick();
                if (b_dec_valid) i++;
                g++;
            end
            b_dec_valid = 1'b0;
            lat = 0;
            while (b_out_valid !== 1'b1 && lat < 100) begin
                tick();
                lat++;
            end
            checks++; if (lat !== 32) begin errors++; $display("FAIL t6_latency[%0d]: got %0d want 32", f, lat); end
            i = 0;
            g = 0;
            bits = 32'h0;
            lasts = 32'h0;
            while (i < 32 && g < 500) begin
                b_out_ready = 1'($urandom_range(0, 1));
                if (b_out_ready && b_out_valid) begin
                    bits[i] = b_out_bit;
                    lasts[i] = b_out_last;
                    i++;
                end
                tick();
                g++;
            end
            b_out_ready = 1'b0;
            checks++; if (bits !== u) begin errors++; $display("FAIL t6_bits[%0d]: got %h want %h", f, bits, u); end
            checks++; if (lasts !== 32'h8000_0000 || b_busy !== 1'b0) begin errors++; $display("FAIL t6_last[%0d]: got %h busy=%b want 80000000 busy=0", f, lasts, b_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_known_frame();
        test_stall();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
